button_click_decoder: RTL and testbench

Classifies debounced button presses into single, double and multi clicks. It sits directly downstream of the button debouncer, whose one-cycle release pulse drives `in_pulse`. It counts pulses that arrive within a rolling time window and emits one classified event per click sequence for the UI/control logic.

---
 rtl/button_pkg.sv | 16 +
 rtl/button_click_decoder.sv | 96 +++++++++
 tb/tb_button_click_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared enums for the button path: debouncer button state and click-decoder FSM state.
package button_pkg;

  typedef enum logic [1:0] {
    BtnReleased,
    BtnPressPending,
    BtnPressed,
    BtnReleasePending
  } t_buttonstate;

  typedef enum logic {
    Idle,
    Collect
  } t_clickstate;

endpackage

// File: rtl/button_click_decoder.sv
// Groups debounced click pulses that arrive within a rolling window and emits
// one single/double/multi event per sequence.
module button_click_decoder
  import button_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = 1000,
  parameter int unsigned WINDOW_BITS  = $clog2(WINDOW_TICKS) + 1,
  parameter int unsigned MAX_CLICKS   = 3,
  parameter int unsigned COUNT_BITS   = $clog2(MAX_CLICKS + 1)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_pulse,
  output logic                  out_valid,
  output logic [COUNT_BITS-1:0] out_count,
  output logic                  out_single,
  output logic                  out_double,
  output logic                  out_multi,
  output logic                  out_busy
);

  localparam logic [WINDOW_BITS-1:0] TimerLast = WINDOW_BITS'(WINDOW_TICKS - 1);
  localparam logic [COUNT_BITS-1:0]  CountMax  = COUNT_BITS'(MAX_CLICKS);

  t_clickstate             state, state_d;
  logic [WINDOW_BITS-1:0]  timer, timer_d;
  logic [COUNT_BITS-1:0]   count, count_d, count_inc, emit_count;
  logic                    emit;

  assign count_inc = count + 1'b1;
  assign out_busy  = (state == Collect);

  // A pulse in the timeout cycle is checked first, so it extends the sequence.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    count_d    = count;
    emit       = 1'b0;
    emit_count = count;
    case (state)
      Idle: begin
        if (in_pulse) begin
          count_d = COUNT_BITS'(1);
          timer_d = '0;
          state_d = Collect;
        end
      end
      Collect: begin
        if (in_pulse) begin
          if (count_inc == CountMax) begin
            emit       = 1'b1;
            emit_count = count_inc;
            state_d    = Idle;
            count_d    = '0;
            timer_d    = '0;
          end else begin
            count_d = count_inc;
            timer_d = '0;
          end
        end else if (timer == TimerLast) begin
          emit       = 1'b1;
          emit_count = count;
          state_d    = Idle;
          count_d    = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state      <= Idle;
      timer      <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_single <= 1'b0;
      out_double <= 1'b0;
      out_multi  <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      count      <= count_d;
      out_valid  <= emit;
      out_single <= emit && (emit_count == COUNT_BITS'(1));
      out_double <= emit && (emit_count == COUNT_BITS'(2));
      out_multi  <= emit && (32'(emit_count) >= 32'd3);
      if (emit) out_count <= emit_count;
    end
  end

endmodule

// File: tb/tb_button_click_decoder.sv
// Directed bench for button_click_decoder with WINDOW_TICKS=10, MAX_CLICKS=3.
module tb_button_click_decoder;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_pulse;
  logic       out_valid;
  logic [1:0] out_count;
  logic       out_single;
  logic       out_double;
  logic       out_multi;
  logic       out_busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [1:0]  held_count;

  button_click_decoder #(
    .WINDOW_TICKS(10),
    .MAX_CLICKS  (3)
  ) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_pulse  (in_pulse),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_single(out_single),
    .out_double(out_double),
    .out_multi (out_multi),
    .out_busy  (out_busy)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    string       name;
    int          len;
    logic [63:0] pulses;
    int          v1;
    logic [1:0]  c1;
    int          v2;
    logic [1:0]  c2;
    int          b1lo, b1hi, b2lo, b2hi;
  } t_vec;

  t_vec tbl [6];

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_outputs(input int cyc, input logic ev, input logic [1:0] ec,
                             input logic eb);
    chk("valid",  cyc, 32'(out_valid),  32'(ev));
    chk("single", cyc, 32'(out_single), 32'(ev && ec == 2'd1));
    chk("double", cyc, 32'(out_double), 32'(ev && ec == 2'd2));
    chk("multi",  cyc, 32'(out_multi),  32'(ev && ec == 2'd3));
    chk("count",  cyc, 32'(out_count),  32'(ec));
    chk("busy",   cyc, 32'(out_busy),   32'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"idle",      30, 64'h0,                          -1, 2'd0, -1, 2'd0, -1, -2, -1, -2};
    tbl[1] = '{"single",    14, 64'h1,                          11, 2'd1, -1, 2'd0,  1, 10, -1, -2};
    tbl[2] = '{"double",    19, 64'h1 | (64'h1 << 5),           16, 2'd2, -1, 2'd0,  1, 15, -1, -2};
    tbl[3] = '{"multi",     12, 64'h1 | (64'h1 << 4) | (64'h1 << 8), 9, 2'd3, -1, 2'd0, 1, 8, -1, -2};
    tbl[4] = '{"edge_pulse", 35, 64'h1 | (64'h1 << 10) | (64'h1 << 21), 21, 2'd2, 32, 2'd1, 1, 20, 22, 31};
    tbl[5] = '{"burst",      6, 64'h7,                           3, 2'd3, -1, 2'd0,  1, 2, -1, -2};

    in_rst   = 1'b1;
    in_pulse = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    chk_outputs(-1, 1'b0, 2'd0, 1'b0);
    in_rst     = 1'b0;
    held_count = 2'd0;

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < tbl[i].len; c++) begin
        logic ev;
        logic eb;
        in_pulse = tbl[i].pulses[c];
        ev = (c == tbl[i].v1) || (c == tbl[i].v2);
        if (c == tbl[i].v1) held_count = tbl[i].c1;
        if (c == tbl[i].v2) held_count = tbl[i].c2;
        eb = (c >= tbl[i].b1lo && c <= tbl[i].b1hi) ||
             (c >= tbl[i].b2lo && c <= tbl[i].b2hi);
        chk_outputs(c, ev, held_count, eb);
        @(posedge in_clk);
        #1;
      end
      in_pulse = 1'b0;
    end

    // Reset mid-sequence: pulse at cycle 0, reset pulse during cycle 5.
    in_pulse = 1'b1;
    @(posedge in_clk);
    #1;
    in_pulse = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk_outputs(c, 1'b0, held_count, 1'b1);
      @(posedge in_clk);
      #1;
    end
    chk("busy_pre_rst", 5, 32'(out_busy), 32'd1);
    in_rst = 1'b1;
    #1;
    held_count = 2'd0;
    chk_outputs(5, 1'b0, held_count, 1'b0);
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    for (int c = 6; c < 26; c++) begin
      chk_outputs(c, 1'b0, held_count, 1'b0);
      @(posedge in_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
